// File: rtl/st2bus_pack.sv
// st2bus_pack: packs Avalon-ST hard-bit beats LSB-first into wide bus words.
// Define ST2BUS_STATUS_WORD_EN to append a per-packet status word after the data.
module st2bus_pack #(
    parameter int BUS              = 512,
    parameter int ST               = 8,
    parameter int NUM_ST_PER_BUS   = 64,
    parameter int ST_PER_TURBO_PKT = 128
) (
    input  logic           clk_bus,
    input  logic           rst_n,
    input  logic [ST-1:0]  st_data,
    input  logic           st_valid,
    input  logic           st_sop,
    input  logic           st_eop,
    input  logic           st_error,
    output logic           st_ready,
    output logic [BUS-1:0] bus_data,
    output logic           bus_valid,
    output logic           bus_last,
    input  logic           bus_ready,
    output logic           pkt_done,
    output logic [3:0]     pkt_status
);
    localparam int PW = ST * NUM_ST_PER_BUS;
    localparam int NUM_BUS_PER_PKT =
        (ST_PER_TURBO_PKT + NUM_ST_PER_BUS - 1) / NUM_ST_PER_BUS;
    localparam int BW = (NUM_ST_PER_BUS > 1) ? $clog2(NUM_ST_PER_BUS) : 1;
    localparam int WW = (NUM_BUS_PER_PKT > 1) ? $clog2(NUM_BUS_PER_PKT) : 1;
    localparam int CW = 16;
    localparam logic [BW-1:0] BEAT_MAX = BW'(NUM_ST_PER_BUS - 1);
    localparam logic [WW-1:0] WORD_MAX = WW'(NUM_BUS_PER_PKT - 1);
    localparam logic [CW-1:0] PKT_MAX  = CW'(ST_PER_TURBO_PKT);

`ifdef ST2BUS_STATUS_WORD_EN
    typedef enum logic [2:0] {IDLE, PACK, DROP, TAIL, STAT} state_t;
    localparam logic LAST_ON_DATA = 1'b0;
`else
    typedef enum logic [1:0] {IDLE, PACK, DROP, TAIL} state_t;
    localparam logic LAST_ON_DATA = 1'b1;
`endif

    state_t        state;
    logic          active;
    logic [PW-1:0] acc;
    logic [BW-1:0] beat_cnt;
    logic [WW-1:0] word_cnt;
    logic [CW-1:0] pkt_beats;
    logic          err_acc;
`ifdef ST2BUS_STATUS_WORD_EN
    state_t        ret_state;
    logic [CW-1:0] stat_cnt;
`endif

    logic          out_free;
    logic          beat_acc;
    logic          abort;
    logic          word_full;
    logic          end_long;
    logic          e_next;
    logic [BW-1:0] b_base;
    logic [WW-1:0] w_base;
    logic [CW-1:0] p_next;
    logic [PW-1:0] a_ins;
    state_t        end_state;

    assign out_free = !bus_valid || bus_ready;
`ifdef ST2BUS_STATUS_WORD_EN
    assign st_ready = active && out_free && (state != STAT) && (state != TAIL);
`else
    assign st_ready = active && out_free && (state != TAIL);
`endif
    assign beat_acc = st_valid && st_ready;

    // Merge the incoming beat into its word; a sop beat always opens a fresh packet.
    always_comb begin
        b_base    = st_sop ? '0 : beat_cnt;
        w_base    = st_sop ? '0 : word_cnt;
        p_next    = (st_sop ? '0 : pkt_beats) + CW'(1);
        e_next    = st_error || (!st_sop && err_acc);
        a_ins     = st_sop ? '0 : acc;
        a_ins[int'(b_base)*ST +: ST] = st_data;
        abort     = st_sop && (state == PACK);
        word_full = (b_base == BEAT_MAX);
        end_long  = !st_eop && (p_next == PKT_MAX);
        end_state = end_long ? DROP : IDLE;
    end

    // Packet FSM, packing accumulator and the single-entry output word register.
    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            state      <= IDLE;
            active     <= 1'b0;
            acc        <= '0;
            beat_cnt   <= '0;
            word_cnt   <= '0;
            pkt_beats  <= '0;
            err_acc    <= 1'b0;
            bus_data   <= '0;
            bus_valid  <= 1'b0;
            bus_last   <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_status <= '0;
`ifdef ST2BUS_STATUS_WORD_EN
            ret_state  <= IDLE;
            stat_cnt   <= '0;
`endif
        end else begin
            active   <= 1'b1;
            pkt_done <= bus_valid && bus_ready && bus_last;
            if (bus_valid && bus_ready) begin
                bus_valid <= 1'b0;
                bus_last  <= 1'b0;
            end
            unique case (state)
                IDLE, PACK, DROP: begin
                    if (beat_acc && abort) begin
                        // Close the interrupted packet; the sop beat seeds the next one.
                        bus_data   <= BUS'(acc);
                        bus_valid  <= 1'b1;
                        bus_last   <= LAST_ON_DATA;
                        pkt_status <= {err_acc, 3'b100};
                        acc        <= a_ins;
                        beat_cnt   <= b_base + BW'(1);
                        word_cnt   <= '0;
                        pkt_beats  <= p_next;
                        err_acc    <= e_next;
`ifdef ST2BUS_STATUS_WORD_EN
                        stat_cnt   <= pkt_beats;
                        ret_state  <= st_eop ? TAIL : PACK;
                        state      <= STAT;
`else
                        state      <= st_eop ? TAIL : PACK;
`endif
                    end else if (beat_acc && (st_sop || state == PACK) &&
                                 (st_eop || end_long)) begin
                        bus_data   <= BUS'(a_ins);
                        bus_valid  <= 1'b1;
                        bus_last   <= LAST_ON_DATA;
                        pkt_status <= {e_next, 1'b0, end_long,
                                       st_eop && (p_next != PKT_MAX)};
                        acc        <= '0;
                        beat_cnt   <= '0;
                        word_cnt   <= '0;
                        pkt_beats  <= '0;
                        err_acc    <= 1'b0;
`ifdef ST2BUS_STATUS_WORD_EN
                        stat_cnt   <= p_next;
                        ret_state  <= end_state;
                        state      <= STAT;
`else
                        state      <= end_state;
`endif
                    end else if (beat_acc && (st_sop || state == PACK)) begin
                        acc       <= word_full ? '0 : a_ins;
                        beat_cnt  <= word_full ? '0 : b_base + BW'(1);
                        word_cnt  <= (word_full && w_base != WORD_MAX) ?
                                     w_base + WW'(1) : w_base;
                        pkt_beats <= p_next;
                        err_acc   <= e_next;
                        state     <= PACK;
                        if (word_full) begin
                            bus_data  <= BUS'(a_ins);
                            bus_valid <= 1'b1;
                            bus_last  <= 1'b0;
                        end
                    end else if (beat_acc && state == DROP && st_eop) begin
                        state <= IDLE;
                    end
                end
                TAIL: begin
                    // A sop+eop beat that aborted a packet is emitted once the register frees.
                    if (out_free) begin
                        bus_data   <= BUS'(acc);
                        bus_valid  <= 1'b1;
                        bus_last   <= LAST_ON_DATA;
                        pkt_status <= {err_acc, 3'b001};
                        acc        <= '0;
                        beat_cnt   <= '0;
                        word_cnt   <= '0;
                        pkt_beats  <= '0;
                        err_acc    <= 1'b0;
`ifdef ST2BUS_STATUS_WORD_EN
                        stat_cnt   <= pkt_beats;
                        ret_state  <= IDLE;
                        state      <= STAT;
`else
                        state      <= IDLE;
`endif
                    end
                end
`ifdef ST2BUS_STATUS_WORD_EN
                STAT: begin
                    if (out_free) begin
                        bus_data  <= BUS'({pkt_status, stat_cnt});
                        bus_valid <= 1'b1;
                        bus_last  <= 1'b1;
                        state     <= ret_state;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_st2bus_pack.sv
// tb_st2bus_pack: directed plus random packets against a packet-level model.
// Honours ST2BUS_STATUS_WORD_EN when the design is built with it.
module tb_st2bus_pack;
    localparam int BUS  = 512;
    localparam int ST   = 8;
    localparam int NPB  = 64;
    localparam int MAXB = 128;
`ifdef ST2BUS_STATUS_WORD_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic           clk_bus;
    logic           rst_n;
    logic [ST-1:0]  st_data;
    logic           st_valid;
    logic           st_sop;
    logic           st_eop;
    logic           st_error;
    logic           st_ready;
    logic [BUS-1:0] bus_data;
    logic           bus_valid;
    logic           bus_last;
    logic           bus_ready;
    logic           pkt_done;
    logic [3:0]     pkt_status;

    st2bus_pack dut (
        .clk_bus(clk_bus), .rst_n(rst_n),
        .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop),
        .st_eop(st_eop), .st_error(st_error), .st_ready(st_ready),
        .bus_data(bus_data), .bus_valid(bus_valid), .bus_last(bus_last),
        .bus_ready(bus_ready), .pkt_done(pkt_done), .pkt_status(pkt_status)
    );

    typedef struct {
        logic [BUS-1:0] d;
        bit             last;
        logic [3:0]     st;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  cur[$];
    int          base;
    int          mode;
    bit          perr;
    bit          done_exp;
    int          checks;
    int          errors;
    int          cyc;
    int          br_mode;
    int          win_lo;
    int          win_hi;

    initial begin
        clk_bus = 1'b0;
        forever #5 clk_bus = ~clk_bus;
    end

    task automatic check(input string tag, input logic [BUS-1:0] obs,
                         input logic [BUS-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [BUS-1:0] chunk(input int from, input int n);
        logic [BUS-1:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[k*ST +: ST] = cur[from+k];
        return w;
    endfunction

    function automatic void push_exp(input logic [BUS-1:0] d, input bit last,
                                     input logic [3:0] s);
        exp_t e;
        e.d = d;
        e.last = last;
        e.st = s;
        exp_q.push_back(e);
    endfunction

    // kind: 0 eop, 1 cut at max length, 2 aborted by a new sop
    function automatic void finish_pkt(input int kind);
        int n;
        logic [3:0] s;
        logic [BUS-1:0] w;
        n = cur.size();
        case (kind)
            0: s = {perr, 2'b00, n != MAXB};
            1: s = {perr, 3'b010};
            default: s = {perr, 3'b100};
        endcase
        push_exp(chunk(base, n - base), !STAT_EN, s);
        if (STAT_EN) begin
            w = '0;
            w[15:0] = 16'(n);
            w[19:16] = s;
            push_exp(w, 1'b1, s);
        end
        mode = (kind == 1) ? 2 : 0;
        cur.delete();
        base = 0;
    endfunction

    function automatic void model_beat(input logic [7:0] d, input bit sop,
                                       input bit eop, input bit err);
        if (sop) begin
            if (mode == 1) finish_pkt(2);
            cur.delete();
            base = 0;
            perr = err;
            cur.push_back(d);
            mode = 1;
        end else if (mode == 1) begin
            cur.push_back(d);
            perr = perr | err;
        end else begin
            if (mode == 2 && eop) mode = 0;
            return;
        end
        if (eop) finish_pkt(0);
        else if (cur.size() == MAXB) finish_pkt(1);
        else if (cur.size() - base == NPB) begin
            push_exp(chunk(base, NPB), 1'b0, 4'b0);
            base += NPB;
        end
    endfunction

    // Output-side monitor and reference-model update, sampled mid-cycle.
    always @(negedge clk_bus) begin
        exp_t e;
        if (!rst_n) begin
            mode = 0;
            base = 0;
            cur.delete();
            exp_q.delete();
            done_exp = 1'b0;
        end else begin
            check("pkt_done", pkt_done, done_exp);
            done_exp = 1'b0;
            if (bus_valid && !bus_ready) check("st_ready_held", st_ready, 1'b0);
            if (bus_valid && bus_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_data", bus_data, e.d);
                    check("bus_last", bus_last, e.last);
                    if (e.last) begin
                        check("pkt_status", pkt_status, e.st);
                        done_exp = 1'b1;
                    end
                end
            end
            if (st_valid && st_ready) model_beat(st_data, st_sop, st_eop, st_error);
        end
    end

    // Memory-writer side acceptance pattern.
    initial begin
        cyc = 0;
        bus_ready = 1'b1;
        forever begin
            @(posedge clk_bus);
            #1;
            cyc++;
            case (br_mode)
                0: bus_ready = 1'b1;
                1: bus_ready = !(cyc >= win_lo && cyc < win_hi);
                default: bus_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_bus);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input bit sop, input bit eop,
                        input bit err);
        int n;
        bit took;
        n = 0;
        took = 1'b0;
        st_data = d;
        st_sop = sop;
        st_eop = eop;
        st_error = err;
        st_valid = 1'b1;
        while (!took && n < 2000) begin
            @(negedge clk_bus);
            took = st_ready;
            @(posedge clk_bus);
            #1;
            n++;
        end
        if (!took) check("beat_timeout", 1'b0, 1'b1);
        st_valid = 1'b0;
        st_sop = 1'b0;
        st_eop = 1'b0;
        st_error = 1'b0;
    endtask

    task automatic send_pkt(input int len, input bit eop_last, input bit rnd);
        logic [7:0] d;
        bit er;
        for (int i = 0; i < len; i++) begin
            d = rnd ? 8'($urandom) : 8'(i);
            er = rnd ? ($urandom_range(0, 31) == 0) : 1'b0;
            send(d, i == 0, eop_last && (i == len - 1), er);
            if (rnd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            idle(1);
            n++;
        end
        idle(4);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic reset_checks();
        check("rst_st_ready", st_ready, 1'b0);
        check("rst_bus_valid", bus_valid, 1'b0);
        check("rst_bus_last", bus_last, 1'b0);
        check("rst_bus_data", bus_data, '0);
        check("rst_pkt_done", pkt_done, 1'b0);
        check("rst_pkt_status", pkt_status, 4'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        br_mode = 0;
        win_lo = 0;
        win_hi = 0;
        mode = 0;
        base = 0;
        perr = 1'b0;
        done_exp = 1'b0;
        rst_n = 1'b0;
        st_data = '0;
        st_valid = 1'b0;
        st_sop = 1'b0;
        st_eop = 1'b0;
        st_error = 1'b0;
        idle(3);
        reset_checks();
        rst_n = 1'b1;
        idle(2);

        // normal 128-beat packet
        send_pkt(128, 1'b1, 1'b0);
        drain();

        // output backpressure while the packet streams
        win_lo = cyc + 30;
        win_hi = cyc + 90;
        br_mode = 1;
        send_pkt(128, 1'b1, 1'b0);
        drain();
        br_mode = 0;

        // short packet
        send_pkt(70, 1'b1, 1'b0);
        drain();

        // long packet, tail beats dropped
        send_pkt(130, 1'b1, 1'b0);
        drain();

        // abort by a new sop, then a normal packet
        send_pkt(10, 1'b0, 1'b0);
        send_pkt(128, 1'b1, 1'b0);
        drain();

        // reset mid-packet discards partial data
        send_pkt(40, 1'b0, 1'b0);
        rst_n = 1'b0;
        idle(2);
        reset_checks();
        rst_n = 1'b1;
        idle(1);
        send_pkt(128, 1'b1, 1'b0);
        drain();

        // random packets with random backpressure, aborts and stray beats
        br_mode = 2;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 7) == 0) send(8'($urandom), 1'b0, 1'b0, 1'b0);
            send_pkt($urandom_range(1, 140), $urandom_range(0, 4) != 0, 1'b1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
        end
        send_pkt(100, 1'b1, 1'b1);
        br_mode = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
